// File: rtl/spram_arbiter.sv
// Two-port (fetch I / load-store D) arbiter in front of a single-port 32-bit SPRAM.
// Optional stall counters are built when SPRAM_ARB_PERF_CNT_EN is defined.
module spram_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [13:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [13:0] d_addr,
    input  logic        d_wen,
    input  logic [3:0]  d_ben,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_ben,
    input  logic [31:0] mem_rdata
`ifdef SPRAM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] i_stall_cnt,
    output logic [31:0] d_stall_cnt
`endif
);

    // state    | meaning
    // OWN_NONE | nothing issued last cycle, no response due
    // OWN_I    | fetch read issued last cycle, i_rvalid due now
    // OWN_D    | data read/write issued last cycle, d_rvalid due now
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [3:0]  r_streak;
    logic [1:0]  r_owner;
    logic [13:0] r_addr_hold;

    logic        w_streak_hit;
    logic        w_gnt_i;
    logic        w_gnt_d;

    // D wins contention until it has taken STREAK_MAX grants in a row over a waiting I.
    assign w_streak_hit = (r_streak == STREAK_MAX);
    assign w_gnt_d      = ~rst & d_req & ~(i_req & w_streak_hit);
    assign w_gnt_i      = ~rst & i_req & ~w_gnt_d;

    assign i_gnt = w_gnt_i;
    assign d_gnt = w_gnt_d;

    always_comb begin
        mem_addr  = r_addr_hold;
        mem_wdata = d_wdata;
        mem_wen   = 1'b0;
        mem_ben   = 4'b0000;
        if (w_gnt_d) begin
            mem_addr = d_addr;
            mem_wen  = d_wen;
            mem_ben  = d_ben;
        end else if (w_gnt_i) begin
            mem_addr = i_addr;
            mem_ben  = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak    <= 4'd0;
            r_owner     <= OWN_NONE;
            r_addr_hold <= 14'd0;
        end else begin
            if (!i_req || w_gnt_i) begin
                r_streak <= 4'd0;
            end else if (w_gnt_d && !w_streak_hit) begin
                r_streak <= r_streak + 4'd1;
            end

            if (w_gnt_d) begin
                r_owner <= OWN_D;
            end else if (w_gnt_i) begin
                r_owner <= OWN_I;
            end else begin
                r_owner <= OWN_NONE;
            end

            if (w_gnt_d || w_gnt_i) begin
                r_addr_hold <= mem_addr;
            end
        end
    end

    // Response of an access caught by reset is dropped, not delivered.
    assign i_rvalid = ~rst & (r_owner == OWN_I);
    assign d_rvalid = ~rst & (r_owner == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

`ifdef SPRAM_ARB_PERF_CNT_EN
    logic [31:0] r_i_stall;
    logic [31:0] r_d_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_stall <= 32'd0;
            r_d_stall <= 32'd0;
        end else begin
            if (i_req && !w_gnt_i) begin
                r_i_stall <= r_i_stall + 32'd1;
            end
            if (d_req && !w_gnt_d) begin
                r_d_stall <= r_d_stall + 32'd1;
            end
        end
    end

    assign i_stall_cnt = r_i_stall;
    assign d_stall_cnt = r_d_stall;
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: SPRAM model, response scoreboard, per-scenario tasks.
// Stall counter checks are built when SPRAM_ARB_PERF_CNT_EN is defined.
module tb_spram_arbiter;

    localparam logic [31:0] C_FETCH = 32'hDEAD_BEEF;
    localparam logic [31:0] C_W20   = 32'h1122_3344;
    localparam logic [31:0] C_W01   = 32'h0101_A5A5;
    localparam logic [31:0] C_W02   = 32'h0202_5A5A;
    localparam logic [31:0] C_W03   = 32'h0303_C3C3;
    localparam logic [31:0] C_W04   = 32'h0404_3C3C;
    localparam logic [31:0] C_W40   = 32'h0BAD_0BAD;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [13:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [13:0] d_addr;
    logic        d_wen;
    logic [3:0]  d_ben;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_ben;
    logic [31:0] mem_rdata;
`ifdef SPRAM_ARB_PERF_CNT_EN
    logic [31:0] i_stall_cnt;
    logic [31:0] d_stall_cnt;
`endif

    spram_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wen     (d_wen),
        .d_ben     (d_ben),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ben   (mem_ben),
        .mem_rdata (mem_rdata)
`ifdef SPRAM_ARB_PERF_CNT_EN
        ,
        .i_stall_cnt (i_stall_cnt),
        .d_stall_cnt (d_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SPRAM model: byte-enabled write, registered read, known words loaded on the first edge.
    logic [31:0] mem [0:16383];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[14'h0010] <= C_FETCH;
            mem[14'h0020] <= C_W20;
            mem[14'h0001] <= C_W01;
            mem[14'h0002] <= C_W02;
            mem[14'h0003] <= C_W03;
            mem[14'h0004] <= C_W04;
            mem[14'h0040] <= C_W40;
            mem_loaded    <= 1'b1;
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_ben[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void push_exp(bit is_d, bit chk, logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.data = data;
        e.due  = cyc + 1;
        q.push_back(e);
    endfunction

    // Response monitor: every rvalid must match the head of the scoreboard on its due cycle.
    always @(negedge clk) begin
        if (i_rvalid || d_rvalid) begin
            n_cmp++;
            if (q.size() == 0 || q[0].due != cyc) begin
                n_err++;
                $display("FAIL rsp_unexpected: cyc=%0d i_rvalid=%0b d_rvalid=%0b, no response due", cyc, i_rvalid, d_rvalid);
            end else begin
                mon_e = q.pop_front();
                if ({i_rvalid, d_rvalid} !== {!mon_e.is_d, mon_e.is_d}) begin
                    n_err++;
                    $display("FAIL rsp_port: cyc=%0d got i_rvalid=%0b d_rvalid=%0b, want %0b %0b", cyc, i_rvalid, d_rvalid, !mon_e.is_d, mon_e.is_d);
                end else if (mon_e.chk && ((mon_e.is_d ? d_rdata : i_rdata) !== mon_e.data)) begin
                    n_err++;
                    $display("FAIL rsp_data: cyc=%0d port=%s got %h want %h", cyc, mon_e.is_d ? "D" : "I", mon_e.is_d ? d_rdata : i_rdata, mon_e.data);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            n_cmp++;
            n_err++;
            mon_e = q.pop_front();
            $display("FAIL rsp_missing: cyc=%0d no rvalid, want port %s", cyc, mon_e.is_d ? "D" : "I");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        i_req = 1'b0;
        d_req = 1'b0;
        d_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_wen = 1'b1;
        d_ben = 4'hF; d_addr = 14'h0040; i_addr = 14'h0001; d_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_cmp++; if ({i_gnt, d_gnt} !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", {i_gnt, d_gnt}); end
        n_cmp++; if (mem_wen !== 1'b0) begin n_err++; $display("FAIL reset_mem_wen: got %b want 0", mem_wen); end
        n_cmp++; if (mem_ben !== 4'b0000) begin n_err++; $display("FAIL reset_mem_ben: got %b want 0000", mem_ben); end
        tick();
        @(negedge clk);
        n_cmp++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", {i_rvalid, d_rvalid}); end
        tick();
        idle_reqs();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({i_gnt, d_gnt} !== 2'b00) begin n_err++; $display("FAIL idle_gnt: got %b want 00", {i_gnt, d_gnt}); end
    endtask

    task automatic test_single_fetch();
        tick();
        i_req = 1'b1; i_addr = 14'h0010;
        @(negedge clk);
        n_cmp++; if ({i_gnt, d_gnt} !== 2'b10) begin n_err++; $display("FAIL fetch_gnt: got %b want 10", {i_gnt, d_gnt}); end
        n_cmp++; if (mem_addr !== 14'h0010 || mem_wen !== 1'b0) begin n_err++; $display("FAIL fetch_mem: got addr %h wen %b want 0010 0", mem_addr, mem_wen); end
        push_exp(1'b0, 1'b1, C_FETCH);
        tick();
        i_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_d_rvalid: got %b want 0", d_rvalid); end
        n_cmp++; if (i_rvalid !== 1'b1 || i_rdata !== C_FETCH) begin n_err++; $display("FAIL fetch_rsp: got %b/%h want 1/%h", i_rvalid, i_rdata, C_FETCH); end
    endtask

    task automatic test_byte_write();
        tick();
        d_req = 1'b1; d_wen = 1'b1; d_addr = 14'h0020; d_ben = 4'b0100; d_wdata = 32'h00AB_0000;
        @(negedge clk);
        n_cmp++; if ({i_gnt, d_gnt} !== 2'b01) begin n_err++; $display("FAIL wr_gnt: got %b want 01", {i_gnt, d_gnt}); end
        n_cmp++; if (mem_wen !== 1'b1 || mem_ben !== 4'b0100 || mem_addr !== 14'h0020 || mem_wdata !== 32'h00AB_0000) begin
            n_err++; $display("FAIL wr_mem: got wen %b ben %b addr %h wdata %h", mem_wen, mem_ben, mem_addr, mem_wdata);
        end
        push_exp(1'b1, 1'b0, 32'h0);
        tick();
        d_wen = 1'b0; d_ben = 4'hF;
        @(negedge clk);
        n_cmp++; if (d_gnt !== 1'b1 || mem_wen !== 1'b0) begin n_err++; $display("FAIL rd_gnt: got gnt %b wen %b want 1 0", d_gnt, mem_wen); end
        push_exp(1'b1, 1'b1, 32'h11AB_3344);
        tick();
        idle_reqs();
        @(negedge clk);
        n_cmp++; if (mem_addr !== 14'h0020 || mem_ben !== 4'b0000 || mem_wen !== 1'b0) begin
            n_err++; $display("FAIL idle_hold: got addr %h ben %b wen %b want 0020 0000 0", mem_addr, mem_ben, mem_wen);
        end
    endtask

    task automatic test_contention();
        bit want_i;
        i_addr = 14'h0002; d_addr = 14'h0001; d_wen = 1'b0; d_ben = 4'hF;
        for (int k = 0; k < 12; k++) begin
            tick();
            i_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            want_i = ((k % 5) == 4);
            n_cmp++;
            if ({i_gnt, d_gnt} !== {want_i, !want_i}) begin
                n_err++; $display("FAIL contention_gnt[%0d]: got %b want %b", k, {i_gnt, d_gnt}, {want_i, !want_i});
            end
            if (want_i) push_exp(1'b0, 1'b1, C_W02);
            else        push_exp(1'b1, 1'b1, C_W01);
        end
        tick();
        idle_reqs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [13:0] a;
        logic [31:0] w [4];
        w[0] = C_W01; w[1] = C_W02; w[2] = C_W03; w[3] = C_W04;
        d_wen = 1'b0; d_ben = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            a = 14'(k + 1);
            i_req = (k % 2 == 0); d_req = (k % 2 == 1);
            i_addr = a; d_addr = a;
            @(negedge clk);
            n_cmp++;
            if ({i_gnt, d_gnt} !== {i_req, d_req}) begin
                n_err++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, {i_gnt, d_gnt}, {i_req, d_req});
            end
            push_exp(k % 2 == 1, 1'b1, w[k]);
        end
        tick();
        idle_reqs();
        @(negedge clk);
    endtask

    task automatic test_write_then_fetch();
        tick();
        d_req = 1'b1; d_wen = 1'b1; d_addr = 14'h0030; d_ben = 4'hF; d_wdata = 32'hCAFE_F00D;
        i_req = 1'b1; i_addr = 14'h0030;
        @(negedge clk);
        n_cmp++; if ({i_gnt, d_gnt} !== 2'b01) begin n_err++; $display("FAIL wf_gnt_d: got %b want 01", {i_gnt, d_gnt}); end
        push_exp(1'b1, 1'b0, 32'h0);
        tick();
        d_req = 1'b0; d_wen = 1'b0;
        @(negedge clk);
        n_cmp++; if ({i_gnt, d_gnt} !== 2'b10) begin n_err++; $display("FAIL wf_gnt_i: got %b want 10", {i_gnt, d_gnt}); end
        push_exp(1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        idle_reqs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit want_i;
        i_addr = 14'h0002; d_addr = 14'h0001; d_wen = 1'b0; d_ben = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            i_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            n_cmp++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL rm_pre_gnt[%0d]: got %b want 1", k, d_gnt); end
            if (k < 2) push_exp(1'b1, 1'b1, C_W01);
        end
        tick();
        rst = 1'b1; d_wen = 1'b1; d_addr = 14'h0040; d_wdata = 32'h0000_0000;
        @(negedge clk);
        n_cmp++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_err++; $display("FAIL rm_rvalid: got %b want 00", {i_rvalid, d_rvalid}); end
        n_cmp++; if ({i_gnt, d_gnt, mem_wen} !== 3'b000 || mem_ben !== 4'b0000) begin
            n_err++; $display("FAIL rm_outputs: got gnt %b wen %b ben %b want 00 0 0000", {i_gnt, d_gnt}, mem_wen, mem_ben);
        end
        tick();
        rst = 1'b0; d_wen = 1'b0; d_addr = 14'h0001;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            want_i = (k == 4);
            n_cmp++;
            if ({i_gnt, d_gnt} !== {want_i, !want_i}) begin
                n_err++; $display("FAIL rm_streak[%0d]: got %b want %b", k, {i_gnt, d_gnt}, {want_i, !want_i});
            end
            if (want_i) push_exp(1'b0, 1'b1, C_W02);
            else        push_exp(1'b1, 1'b1, C_W01);
        end
        tick();
        i_req = 1'b0; d_addr = 14'h0040;
        @(negedge clk);
        push_exp(1'b1, 1'b1, C_W40);
        tick();
        idle_reqs();
        @(negedge clk);
    endtask

`ifdef SPRAM_ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_addr = 14'h0002; d_addr = 14'h0001; d_wen = 1'b0; d_ben = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            i_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            if ((k % 5) == 4) push_exp(1'b0, 1'b1, C_W02);
            else              push_exp(1'b1, 1'b1, C_W01);
        end
        tick();
        idle_reqs();
        @(negedge clk);
        n_cmp++; if (i_stall_cnt !== 32'd8) begin n_err++; $display("FAIL perf_i_stall: got %0d want 8", i_stall_cnt); end
        n_cmp++; if (d_stall_cnt !== 32'd2) begin n_err++; $display("FAIL perf_d_stall: got %0d want 2", d_stall_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = 14'h0; d_addr = 14'h0; d_ben = 4'h0; d_wdata = 32'h0;
        test_reset();
        test_single_fetch();
        test_byte_write();
        test_contention();
        test_back_to_back();
        test_write_then_fetch();
        test_reset_mid();
`ifdef SPRAM_ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
